// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA raster timing generator.
// A clock divider produces the pixel strobe, h/v counters walk the raster of
// the active timing set, and the derived video signals are delayed through a
// pixel-rate pipeline. A single pending slot holds a new timing set until the
// next frame wrap so that mode changes only ever happen on a frame boundary.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int CNT_W      = 11,
   parameter int CLK_DIV    = 4,
   parameter int PIPE_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_hd,
   input  logic [CNT_W-1:0] cfg_hf,
   input  logic [CNT_W-1:0] cfg_hs,
   input  logic [CNT_W-1:0] cfg_ht,
   input  logic [CNT_W-1:0] cfg_vd,
   input  logic [CNT_W-1:0] cfg_vf,
   input  logic [CNT_W-1:0] cfg_vs,
   input  logic [CNT_W-1:0] cfg_vt,
   input  logic             cfg_hpol,
   input  logic             cfg_vpol,
   output logic             cfg_err,
   output logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             line_start,
   output logic             frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam int SW = CNT_W + 2;

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_nxt;
   logic             pix_en_d;

   logic [CNT_W-1:0] act_hd, act_hf, act_hs, act_ht;
   logic [CNT_W-1:0] act_vd, act_vf, act_vs, act_vt;
   logic             act_hpol, act_vpol;
   logic [CNT_W-1:0] pend_hd, pend_hf, pend_hs, pend_ht;
   logic [CNT_W-1:0] pend_vd, pend_vf, pend_vs, pend_vt;
   logic             pend_hpol, pend_vpol;
   logic             pend_full;

   logic [CNT_W-1:0] h, v;
   logic             h_last, v_last, frame_wrap;
   logic             accept, cfg_ok;
   logic [SW-1:0]    h_tot, v_tot;

   logic [SW-1:0]    hs_beg, hs_end, vs_beg, vs_end;
   logic             de0, hs0, vs0, ls0, fs0;
   logic [CNT_W-1:0] hc0, vc0;

   logic [PIPE_DEPTH-1:0] de_p, hs_p, vs_p, ls_p, fs_p;
   logic [CNT_W-1:0]      hc_p [PIPE_DEPTH];
   logic [CNT_W-1:0]      vc_p [PIPE_DEPTH];

   // next divider value, wrapping after CLK_DIV clocks
   always_comb begin
      div_nxt = div + 1'b1;
      if (div == DIV_LAST) div_nxt = '0;
   end

   // divider and pixel strobe; pix_en is high while the divider sits at its last count
   always_ff @(posedge clk) begin
      if (reset) begin
         div      <= '0;
         pix_en   <= 1'b0;
         pix_en_d <= 1'b0;
      end else begin
         div      <= div_nxt;
         pix_en   <= (div_nxt == DIV_LAST);
         pix_en_d <= pix_en;
      end
   end

   // a timing set is legal when both totals are non-zero and each blanking fits its total
   always_comb begin
      h_tot  = SW'(cfg_hd) + SW'(cfg_hf) + SW'(cfg_hs);
      v_tot  = SW'(cfg_vd) + SW'(cfg_vf) + SW'(cfg_vs);
      cfg_ok = (cfg_ht != '0) && (cfg_vt != '0) &&
               (h_tot <= SW'(cfg_ht)) && (v_tot <= SW'(cfg_vt));
      accept     = cfg_valid && !pend_full;
      h_last     = (h == act_ht - 1'b1);
      v_last     = (v == act_vt - 1'b1);
      frame_wrap = pix_en && h_last && v_last;
   end

   assign cfg_ready = !pend_full;

   // active/pending timing sets; the pending set only takes over at a frame wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         act_hd <= CNT_W'(640); act_hf <= CNT_W'(16); act_hs <= CNT_W'(96); act_ht <= CNT_W'(800);
         act_vd <= CNT_W'(480); act_vf <= CNT_W'(10); act_vs <= CNT_W'(2);  act_vt <= CNT_W'(525);
         act_hpol  <= 1'b0;
         act_vpol  <= 1'b0;
         pend_hd <= '0; pend_hf <= '0; pend_hs <= '0; pend_ht <= '0;
         pend_vd <= '0; pend_vf <= '0; pend_vs <= '0; pend_vt <= '0;
         pend_hpol <= 1'b0;
         pend_vpol <= 1'b0;
         pend_full <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= accept && !cfg_ok;
         if (frame_wrap && pend_full) begin
            act_hd <= pend_hd; act_hf <= pend_hf; act_hs <= pend_hs; act_ht <= pend_ht;
            act_vd <= pend_vd; act_vf <= pend_vf; act_vs <= pend_vs; act_vt <= pend_vt;
            act_hpol  <= pend_hpol;
            act_vpol  <= pend_vpol;
            pend_full <= 1'b0;
         end
         if (accept && cfg_ok) begin
            pend_hd <= cfg_hd; pend_hf <= cfg_hf; pend_hs <= cfg_hs; pend_ht <= cfg_ht;
            pend_vd <= cfg_vd; pend_vf <= cfg_vf; pend_vs <= cfg_vs; pend_vt <= cfg_vt;
            pend_hpol <= cfg_hpol;
            pend_vpol <= cfg_vpol;
            pend_full <= 1'b1;
         end
      end
   end

   // raster position counters, advancing once per pixel
   always_ff @(posedge clk) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   // stage-0 video signals derived from the current position and active set
   always_comb begin
      hs_beg = SW'(act_hd) + SW'(act_hf);
      hs_end = hs_beg + SW'(act_hs);
      vs_beg = SW'(act_vd) + SW'(act_vf);
      vs_end = vs_beg + SW'(act_vs);
      de0 = (h < act_hd) && (v < act_vd);
      hs0 = ((SW'(h) >= hs_beg) && (SW'(h) < hs_end)) ? act_hpol : ~act_hpol;
      vs0 = ((SW'(v) >= vs_beg) && (SW'(v) < vs_end)) ? act_vpol : ~act_vpol;
      hc0 = de0 ? h : '0;
      vc0 = de0 ? v : '0;
      ls0 = (h == '0);
      fs0 = (h == '0) && (v == '0);
   end

   // pixel-rate delay line; syncs are stored already polarised so in-flight pixels keep the old mode
   always_ff @(posedge clk) begin
      if (reset) begin
         de_p <= '0;
         hs_p <= '1;
         vs_p <= '1;
         ls_p <= '0;
         fs_p <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            hc_p[i] <= '0;
            vc_p[i] <= '0;
         end
      end else if (pix_en) begin
         de_p[0] <= de0;
         hs_p[0] <= hs0;
         vs_p[0] <= vs0;
         ls_p[0] <= ls0;
         fs_p[0] <= fs0;
         hc_p[0] <= hc0;
         vc_p[0] <= vc0;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            de_p[i] <= de_p[i-1];
            hs_p[i] <= hs_p[i-1];
            vs_p[i] <= vs_p[i-1];
            ls_p[i] <= ls_p[i-1];
            fs_p[i] <= fs_p[i-1];
            hc_p[i] <= hc_p[i-1];
            vc_p[i] <= vc_p[i-1];
         end
      end
   end

   assign de          = de_p[PIPE_DEPTH-1];
   assign hsync       = hs_p[PIPE_DEPTH-1];
   assign vsync       = vs_p[PIPE_DEPTH-1];
   assign h_cnt       = hc_p[PIPE_DEPTH-1];
   assign v_cnt       = vc_p[PIPE_DEPTH-1];
   assign line_start  = ls_p[PIPE_DEPTH-1] & pix_en_d;
   assign frame_start = fs_p[PIPE_DEPTH-1] & pix_en_d;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. A reference model
// tracks the raster as a linear pixel index inside the frame and pushes the
// expected video word for every pixel it feeds in; a negedge monitor pops and
// compares whenever the DUT presents a new pixel.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int CNT_W = 11;
   localparam int CD    = 2;
   localparam int PD    = 3;

   typedef struct packed {
      logic [CNT_W-1:0] hd, hf, hs, ht, vd, vf, vs, vt;
      logic             hpol, vpol;
   } set_t;

   typedef struct packed {
      logic             de, hs, vs;
      logic [CNT_W-1:0] hc, vc;
      logic             ls, fs;
   } pix_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_hd = '0, cfg_hf = '0, cfg_hs = '0, cfg_ht = '0;
   logic [CNT_W-1:0] cfg_vd = '0, cfg_vf = '0, cfg_vs = '0, cfg_vt = '0;
   logic             cfg_hpol = 1'b0, cfg_vpol = 1'b0;
   logic             cfg_err, pix_en, hsync, vsync, de, line_start, frame_start;
   logic [CNT_W-1:0] h_cnt, v_cnt;

   vga_timing_gen #(.CNT_W(CNT_W), .CLK_DIV(CD), .PIPE_DEPTH(PD)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_hd(cfg_hd), .cfg_hf(cfg_hf), .cfg_hs(cfg_hs), .cfg_ht(cfg_ht),
      .cfg_vd(cfg_vd), .cfg_vf(cfg_vf), .cfg_vs(cfg_vs), .cfg_vt(cfg_vt),
      .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_err(cfg_err),
      .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .de(de),
      .h_cnt(h_cnt), .v_cnt(v_cnt),
      .line_start(line_start), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   set_t m_act, m_pen;
   bit   m_full = 1'b0;
   bit   m_rst = 1'b1;
   bit   m_strobe = 1'b0;
   bit   exp_pix = 1'b0;
   bit   exp_err = 1'b0;
   bit   wrap_next = 1'b0;
   int   m_cnt = 0;
   int   m_pos = 0;
   pix_t q[$];
   pix_t cur;

   int   cyc = 0;
   int   fs_count = 0;
   int   fs_last = 0;

   function automatic set_t mkSet(int hd, int hf, int hs, int ht, int vd, int vf, int vs, int vt,
                                  bit hp, bit vp);
      set_t s;
      s.hd = CNT_W'(hd); s.hf = CNT_W'(hf); s.hs = CNT_W'(hs); s.ht = CNT_W'(ht);
      s.vd = CNT_W'(vd); s.vf = CNT_W'(vf); s.vs = CNT_W'(vs); s.vt = CNT_W'(vt);
      s.hpol = hp; s.vpol = vp;
      return s;
   endfunction

   function automatic pix_t rstPix();
      pix_t r;
      r = '0;
      r.hs = 1'b1;
      r.vs = 1'b1;
      return r;
   endfunction

   function automatic bit setOk(set_t s);
      int ht = s.ht, vt = s.vt;
      int hsum = int'(s.hd) + int'(s.hf) + int'(s.hs);
      int vsum = int'(s.vd) + int'(s.vf) + int'(s.vs);
      return (ht > 0) && (vt > 0) && (hsum <= ht) && (vsum <= vt);
   endfunction

   // expected video word for linear pixel p of a frame of set s
   function automatic pix_t pixelOf(set_t s, int p);
      pix_t r;
      int ht = s.ht;
      int h = p % ht;
      int v = p / ht;
      int hb = int'(s.hd) + int'(s.hf);
      int vb = int'(s.vd) + int'(s.vf);
      r.de = (h < int'(s.hd)) && (v < int'(s.vd));
      r.hs = (h >= hb && h < hb + int'(s.hs)) ? s.hpol : !s.hpol;
      r.vs = (v >= vb && v < vb + int'(s.vs)) ? s.vpol : !s.vpol;
      r.hc = r.de ? CNT_W'(h) : '0;
      r.vc = r.de ? CNT_W'(v) : '0;
      r.ls = (h == 0);
      r.fs = (h == 0) && (v == 0);
      return r;
   endfunction

   function automatic set_t randSet(bit want_ok);
      int ht = $urandom_range(1, 12);
      int vt = $urandom_range(1, 8);
      int hd = $urandom_range(0, ht);
      int hf = $urandom_range(0, ht - hd);
      int hs = $urandom_range(0, ht - hd - hf);
      int vd = $urandom_range(0, vt);
      int vf = $urandom_range(0, vt - vd);
      int vs = $urandom_range(0, vt - vd - vf);
      if (!want_ok) begin
         case ($urandom_range(0, 2))
            0: hs = ht - hd - hf + 1 + $urandom_range(0, 3);
            1: vs = vt - vd - vf + 1 + $urandom_range(0, 3);
            default: ht = 0;
         endcase
      end
      return mkSet(hd, hf, hs, ht, vd, vf, vs, vt, 1'($urandom), 1'($urandom));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         if (n_bad <= 40)
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // reference model: feeds one pixel per pixel strobe and tracks the config handshake
   always @(posedge clk) begin
      if (reset) begin
         m_rst    = 1'b1;
         m_act    = mkSet(640, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0);
         m_full   = 1'b0;
         m_cnt    = 0;
         m_pos    = 0;
         m_strobe = 1'b0;
         exp_pix  = 1'b0;
         exp_err  = 1'b0;
         wrap_next = 1'b0;
         q.delete();
         for (int i = 0; i < PD - 1; i++) q.push_back(rstPix());
      end else begin
         set_t offered;
         bit   accept;
         m_rst  = 1'b0;
         offered = mkSet(cfg_hd, cfg_hf, cfg_hs, cfg_ht, cfg_vd, cfg_vf, cfg_vs, cfg_vt,
                         cfg_hpol, cfg_vpol);
         accept = cfg_valid && !m_full;
         m_cnt++;
         m_strobe = exp_pix;
         if (exp_pix) begin
            q.push_back(pixelOf(m_act, m_pos));
            m_pos++;
            if (m_pos == int'(m_act.ht) * int'(m_act.vt)) begin
               m_pos = 0;
               if (m_full) begin
                  m_act  = m_pen;
                  m_full = 1'b0;
               end
            end
         end
         exp_err = 1'b0;
         if (accept) begin
            if (setOk(offered)) begin
               m_pen  = offered;
               m_full = 1'b1;
            end else begin
               exp_err = 1'b1;
            end
         end
         exp_pix   = ((m_cnt % CD) == CD - 1);
         wrap_next = exp_pix && (m_pos == int'(m_act.ht) * int'(m_act.vt) - 1);
      end
   end

   // monitor: pops one expected word per presented pixel and checks every output
   always @(negedge clk) begin
      cyc++;
      if (m_rst) begin
         cur = rstPix();
         fs_count = 0;
      end else if (m_strobe) begin
         if (q.size() == 0) checkOutput("queue_empty", 32'(q.size()), 32'(1));
         else cur = q.pop_front();
      end
      checkOutput("pix_en", 32'(pix_en), 32'(exp_pix));
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_full));
      checkOutput("cfg_err", 32'(cfg_err), 32'(exp_err));
      checkOutput("de", 32'(de), 32'(cur.de));
      checkOutput("hsync", 32'(hsync), 32'(cur.hs));
      checkOutput("vsync", 32'(vsync), 32'(cur.vs));
      checkOutput("h_cnt", 32'(h_cnt), 32'(cur.hc));
      checkOutput("v_cnt", 32'(v_cnt), 32'(cur.vc));
      checkOutput("line_start", 32'(line_start), 32'(cur.ls && m_strobe));
      checkOutput("frame_start", 32'(frame_start), 32'(cur.fs && m_strobe));
      if (frame_start && !m_rst) begin
         fs_count++;
         if (fs_count == 2)
            checkOutput("default_frame_clks", 32'(cyc - fs_last), 32'(800 * 525 * CD));
         fs_last = cyc;
      end
   end

   // offer one timing set for a single clock; caller sits at a negedge
   task automatic applyStimulus(input set_t s);
      cfg_hd = s.hd; cfg_hf = s.hf; cfg_hs = s.hs; cfg_ht = s.ht;
      cfg_vd = s.vd; cfg_vf = s.vf; cfg_vs = s.vs; cfg_vt = s.vt;
      cfg_hpol = s.hpol; cfg_vpol = s.vpol;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic waitEmpty(input int budget);
      for (int i = 0; i < budget && m_full; i++) @(negedge clk);
      checkOutput("wait_pending_drain", 32'(m_full), 32'(0));
   endtask

   task automatic waitWrap(input int budget);
      for (int i = 0; i < budget && !wrap_next; i++) @(negedge clk);
      checkOutput("wait_frame_wrap", 32'(wrap_next), 32'(1));
   endtask

   // stimulus sequence
   initial begin
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (2 * 800 * CD + 37) @(negedge clk);
      $display("[TB] offering oversized horizontal set");
      applyStimulus(mkSet(700, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0));
      repeat (10) @(negedge clk);
      $display("[TB] offering small set mid-frame");
      applyStimulus(mkSet(4, 1, 2, 8, 3, 1, 1, 6, 1'b1, 1'b1));
      repeat (5) @(negedge clk);
      applyStimulus(randSet(1'b1));
      repeat (3) @(negedge clk);
      applyStimulus(randSet(1'b0));
      waitEmpty(900000);
      repeat (3 * 48 * CD) @(negedge clk);
      $display("[TB] offering set on the frame-wrap clock");
      waitWrap(2000);
      applyStimulus(randSet(1'b1));
      for (int k = 0; k < 60; k++) begin
         repeat ($urandom_range(0, 150)) @(negedge clk);
         applyStimulus(randSet($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 3) == 0) waitEmpty(5000);
         if ($urandom_range(0, 4) == 0) begin
            waitEmpty(5000);
            waitWrap(2000);
            applyStimulus(randSet(1'b1));
         end
      end
      waitEmpty(5000);
      repeat (300) @(negedge clk);
      $display("[TB] reset with a set pending");
      applyStimulus(randSet(1'b1));
      repeat (7) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3000) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CNT_W, default 11, width of all timing counters and timing fields.
REQ-002 Parameter CLK_DIV, default 4, clk cycles per pixel (pix_en period); legal range >=1.
REQ-003 Parameter PIPE_DEPTH, default 2, pixel-stage delay applied to all video outputs; legal range >=1.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  new timing set offered.
REQ-007 cfg_ready  out  1  block can accept a timing set.
REQ-008 cfg_hd/cfg_hf/cfg_hs/cfg_ht  in  CNT_W each  horizontal active, front porch, sync width, total (pixels).
REQ-009 cfg_vd/cfg_vf/cfg_vs/cfg_vt  in  CNT_W each  vertical active, front porch, sync width, total (lines).
REQ-010 cfg_hpol/cfg_vpol  in  1 each  sync active level (1 = active-high).
REQ-011 cfg_err  out  1  one-clk pulse: offered timing set rejected.
REQ-012 pix_en  out  1  one-clk pulse every CLK_DIV clks.
REQ-013 hsync/vsync  out  1 each  sync outputs at programmed polarity.
REQ-014 de  out  1  active video region.
REQ-015 h_cnt/v_cnt  out  CNT_W each  active pixel/line coordinate, 0 outside active region.
REQ-016 line_start/frame_start  out  1 each  one-clk pulses marking pixel (0,y) / pixel (0,0).

Function
REQ-017 pix_en SHALL assert on the clk where the internal divider reaches CLK_DIV-1, then divider returns to 0; CLK_DIV=1 keeps pix_en constantly high.
REQ-018 Internal counters h (0..HT-1) and v (0..VT-1) SHALL advance only on pix_en; h wraps HT-1->0; v increments on h wrap and wraps VT-1->0.
REQ-019 Stage-0 signals from current h,v: de0 = h<HD && v<VD; hsync0 active for HD+HF <= h < HD+HF+HS; vsync0 active for VD+VF <= v < VD+VF+VS; hcnt0/vcnt0 = h/v when active else 0; ls0 = h==0; fs0 = h==0 && v==0.
REQ-020 Stage-0 signals SHALL pass through PIPE_DEPTH registers that shift only on pix_en; hsync/vsync/de/h_cnt/v_cnt are the final stage.
REQ-021 line_start/frame_start SHALL be final-stage ls/fs ANDed with the clk following the pix_en that loaded them, so each pulses exactly one clk per line/frame.
REQ-022 Sync level: output = active ? pol : ~pol, using polarity of the timing set in use.
REQ-023 Timing set in use (active set) and one pending slot; cfg_ready = pending slot empty.
REQ-024 cfg_valid && cfg_ready SHALL accept the set: if valid, store in pending; otherwise drop and pulse cfg_err next clk.
REQ-025 Valid set: HT>0, VT>0, HD+HF+HS <= HT, VD+VF+VS <= VT, sums computed at CNT_W+2 bits (no wrap).
REQ-026 Pending set SHALL become active on the pix_en where h==HT-1 && v==VT-1 (frame wrap); h,v go to 0 and next frame uses new set; pending empties, cfg_ready rises next clk.
REQ-027 Accept on same clk as frame wrap: new set stored in pending, applied at following frame wrap, not current one.
REQ-028 Pipeline stages already in flight at a mode change SHALL drain unchanged (outputs reflect old set until flushed).
REQ-029 cfg_valid while cfg_ready low SHALL be ignored; no cfg_err.

Reset
REQ-030 reset SHALL clear divider, h, v, pipeline stages, pending slot; active set = 640/16/96/800, 480/10/2/525, both polarities 0.
REQ-031 Reset values: pix_en 0, de 0, h_cnt 0, v_cnt 0, line_start 0, frame_start 0, cfg_err 0, cfg_ready 1, hsync 1, vsync 1 (inactive for pol 0).
REQ-032 Reset asserted mid-frame or with pending set SHALL discard pending set and restart at (0,0) with default set; first frame_start PIPE_DEPTH pixels after first pix_en.

Verification
REQ-033 Reset, default set, CLK_DIV=4 -> pix_en every 4 clks; hsync low for 96 pixels starting at h=656; vsync low lines 490-491; 800x525 pixels between frame_start pulses = 1,680,000 clks.
REQ-034 Program HD=4,HF=1,HS=2,HT=8,VD=3,VF=1,VS=1,VT=6, hpol=vpol=1 mid-frame -> cfg_err 0; old timing until frame wrap; then de high 4 of 8 pixels, hsync high h=5-6, vsync high v=4.
REQ-035 Offer HD=700,HF=16,HS=96,HT=800 -> cfg_err pulses one clk, pending stays empty, default timing continues.
REQ-036 Offer second set while pending full -> cfg_ready 0, set ignored, no cfg_err; first set applied at wrap.
REQ-037 Offer set on exact frame-wrap clk -> current frame uses old set, change applies at following wrap.
REQ-038 PIPE_DEPTH=3 -> de, h_cnt, syncs lag stage-0 by exactly 3 pix_en; h_cnt=0..639 and de aligned; line_start coincides with h_cnt=0, de=1.
